// File: rtl/text_scroller_pkg.sv
// Shared types and constants for the text scroller marquee engine.
package text_pkg;

    typedef logic [7:0] char_t;

    localparam char_t CHAR_SPACE = 8'h20;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/text_scroller_if.sv
// Host-side message bus: byte writes into the shadow buffer and the atomic load.
interface text_scroller_if #(
    parameter int MSG_CHARS = 32
);
    import text_pkg::*;

    localparam int AW = $clog2(MSG_CHARS);
    localparam int LW = $clog2(MSG_CHARS + 1);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    char_t         wr_data;
    logic          load;
    logic [LW-1:0] msg_len;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output load,
        output msg_len
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data,
        input load,
        input msg_len
    );

endinterface

// File: rtl/text_scroller_prescaler.sv
// Scroll-rate prescaler: ticks every step_div+1 enabled cycles; clear restarts the count.
module scroll_prescaler #(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] step_div,
    input  logic                 clear,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    // >= rather than == so lowering step_div below cnt steps on the next enabled cycle
    assign tick = en && !clear && (cnt >= step_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt >= step_div) ? '0 : cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/text_scroller.sv
// Marquee engine: shadow/active message buffers, scroll offset and registered window output.
module text_scroller
    import text_pkg::*;
#(
    parameter int MSG_CHARS = 32,
    parameter int WIN_CHARS = 16,
    parameter int DIV_WIDTH = 24,
    localparam int AW = $clog2(MSG_CHARS),
    localparam int LW = $clog2(MSG_CHARS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   dir,
    input  logic [DIV_WIDTH-1:0]   step_div,
    text_scroller_if.slave         wbus,
    output logic [WIN_CHARS*8-1:0] out,
    output logic [AW-1:0]          offset,
    output logic                   step,
    output logic                   wrap
);

    char_t                  shadow [MSG_CHARS];
    char_t                  active [MSG_CHARS];
    logic [LW-1:0]          len_r;
    logic [LW-1:0]          len_c;
    logic [AW-1:0]          next_off;
    logic [AW-1:0]          idx_c;
    logic [WIN_CHARS*8-1:0] win_c;
    logic                   tick;

    scroll_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .step_div(step_div),
        .clear   (wbus.load),
        .tick    (tick)
    );

    always_comb begin
        len_c = wbus.msg_len;
        if (wbus.msg_len == '0 || wbus.msg_len > LW'(MSG_CHARS)) begin
            len_c = LW'(MSG_CHARS);
        end
    end

    always_comb begin
        next_off = offset;
        if (dir == DIR_RIGHT) begin
            next_off = (offset == '0) ? AW'(len_r - LW'(1)) : offset - AW'(1);
        end else begin
            next_off = (LW'(offset) == len_r - LW'(1)) ? '0 : offset + AW'(1);
        end
    end

    // Index wraps at len_r, so a message shorter than the window repeats across it
    always_comb begin
        win_c = '0;
        idx_c = offset;
        for (int unsigned i = 0; i < WIN_CHARS; i++) begin
            win_c[(WIN_CHARS-1-i)*8 +: 8] = active[idx_c];
            idx_c = (LW'(idx_c) == len_r - LW'(1)) ? '0 : idx_c + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 0; j < MSG_CHARS; j++) begin
                shadow[j] <= CHAR_SPACE;
            end
        end else if (wbus.wr_en) begin
            for (int unsigned j = 0; j < MSG_CHARS; j++) begin
                if (wbus.wr_addr == AW'(j)) begin
                    shadow[j] <= wbus.wr_data;
                end
            end
        end
    end

    // Load copies shadow as it stood before any write landing on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 0; j < MSG_CHARS; j++) begin
                active[j] <= CHAR_SPACE;
            end
            len_r  <= LW'(MSG_CHARS);
            offset <= '0;
            step   <= 1'b0;
            wrap   <= 1'b0;
            out    <= {WIN_CHARS{CHAR_SPACE}};
        end else begin
            out <= win_c;
            if (wbus.load) begin
                for (int unsigned j = 0; j < MSG_CHARS; j++) begin
                    active[j] <= shadow[j];
                end
                len_r  <= len_c;
                offset <= '0;
                step   <= 1'b0;
                wrap   <= 1'b0;
            end else begin
                step <= tick;
                wrap <= tick && (next_off == '0);
                if (tick) begin
                    offset <= next_off;
                end
            end
        end
    end

endmodule

// File: tb/tb_text_scroller.sv
// Directed bench for text_scroller: vector table for the short right scroll, hand sequences elsewhere.
module tb_text_scroller;
    import text_pkg::*;

    localparam int MSG_CHARS = 32;
    localparam int WIN_CHARS = 16;
    localparam int DIV_WIDTH = 24;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   en;
    logic                   dir;
    logic [DIV_WIDTH-1:0]   step_div;
    logic [WIN_CHARS*8-1:0] out;
    logic [4:0]             offset;
    logic                   step;
    logic                   wrap;

    int n_cmp = 0;
    int n_bad = 0;

    text_scroller_if #(.MSG_CHARS(MSG_CHARS)) wbus ();

    text_scroller #(
        .MSG_CHARS(MSG_CHARS),
        .WIN_CHARS(WIN_CHARS),
        .DIV_WIDTH(DIV_WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .dir     (dir),
        .step_div(step_div),
        .wbus    (wbus),
        .out     (out),
        .offset  (offset),
        .step    (step),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         load;
        logic [5:0]   len;
        logic         en;
        logic         dir;
        logic [23:0]  div;
        logic         chk_out;
        logic [127:0] e_out;
        logic [4:0]   e_off;
        logic         e_step;
        logic         e_wrap;
    } vec_t;

    vec_t vt [14];

    function automatic vec_t mk(input logic ld, input logic co, input logic [127:0] eo,
                                input logic [4:0] ef, input logic es, input logic ew);
        vec_t v;
        v.load = ld; v.len = 6'd4; v.en = 1'b1; v.dir = 1'b1; v.div = 24'd2;
        v.chk_out = co; v.e_out = eo; v.e_off = ef; v.e_step = es; v.e_wrap = ew;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic write_str(input logic [255:0] s, input int n);
        for (int a = 0; a < n; a++) begin
            wbus.wr_en   = 1'b1;
            wbus.wr_addr = 5'(a);
            wbus.wr_data = s[(n-1-a)*8 +: 8];
            cyc();
        end
        wbus.wr_en = 1'b0;
    endtask

    task automatic chk_pulse(input string nm, input logic [4:0] e_off, input logic e_step, input logic e_wrap);
        chk({nm, "_off"},  128'(offset), 128'(e_off));
        chk({nm, "_step"}, 128'(step),   128'(e_step));
        chk({nm, "_wrap"}, 128'(wrap),   128'(e_wrap));
    endtask

    localparam logic [127:0] SPACES = "                ";
    localparam logic [127:0] W0 = "HI  HI  HI  HI  ";
    localparam logic [127:0] W3 = " HI  HI  HI  HI ";
    localparam logic [127:0] W2 = "  HI  HI  HI  HI";
    localparam logic [127:0] W1 = "I  HI  HI  HI  H";

    initial begin
        vt[0]  = mk(1'b1, 1'b0, '0, 5'd0, 1'b0, 1'b0);
        vt[1]  = mk(1'b0, 1'b1, W0, 5'd0, 1'b0, 1'b0);
        vt[2]  = mk(1'b0, 1'b1, W0, 5'd0, 1'b0, 1'b0);
        vt[3]  = mk(1'b0, 1'b1, W0, 5'd3, 1'b1, 1'b0);
        vt[4]  = mk(1'b0, 1'b1, W3, 5'd3, 1'b0, 1'b0);
        vt[5]  = mk(1'b0, 1'b1, W3, 5'd3, 1'b0, 1'b0);
        vt[6]  = mk(1'b0, 1'b1, W3, 5'd2, 1'b1, 1'b0);
        vt[7]  = mk(1'b0, 1'b1, W2, 5'd2, 1'b0, 1'b0);
        vt[8]  = mk(1'b0, 1'b1, W2, 5'd2, 1'b0, 1'b0);
        vt[9]  = mk(1'b0, 1'b1, W2, 5'd1, 1'b1, 1'b0);
        vt[10] = mk(1'b0, 1'b1, W1, 5'd1, 1'b0, 1'b0);
        vt[11] = mk(1'b0, 1'b1, W1, 5'd1, 1'b0, 1'b0);
        vt[12] = mk(1'b0, 1'b1, W1, 5'd0, 1'b1, 1'b1);
        vt[13] = mk(1'b0, 1'b1, W0, 5'd0, 1'b0, 1'b0);

        en = 1'b0; dir = 1'b0; step_div = '0;
        wbus.wr_en = 1'b0; wbus.wr_addr = '0; wbus.wr_data = '0;
        wbus.load = 1'b0; wbus.msg_len = '0;

        // Reset before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_out", out, SPACES);
        chk_pulse("rst", 5'd0, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;

        // Left scroll of a full 32-char message, step every cycle
        write_str("ABCDEFGHIJKLMNOPQRSTUVWXYZ012345", 32);
        wbus.load = 1'b1; wbus.msg_len = 6'd32; en = 1'b1; dir = 1'b0; step_div = '0;
        cyc();
        wbus.load = 1'b0;
        chk_pulse("t2_load", 5'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 33; k++) begin
            cyc();
            chk_pulse($sformatf("t2_k%0d", k), 5'(k % 32), 1'b1, (k % 32) == 0);
            case (k)
                1:  chk("t2_out1",  out, "ABCDEFGHIJKLMNOP");
                2:  chk("t2_out2",  out, "BCDEFGHIJKLMNOPQ");
                17: chk("t2_out17", out, "QRSTUVWXYZ012345");
                32: chk("t2_out32", out, "5ABCDEFGHIJKLMNO");
                33: chk("t2_out33", out, "ABCDEFGHIJKLMNOP");
                default: ;
            endcase
        end

        // Shadow writes stay invisible until load; load samples pre-write shadow
        en = 1'b0;
        write_str("XYZ", 3);
        chk("t4_nochange", out, "BCDEFGHIJKLMNOPQ");
        chk("t4_off_hold", 128'(offset), 128'(5'd1));
        wbus.load = 1'b1; wbus.msg_len = 6'd3;
        wbus.wr_en = 1'b1; wbus.wr_addr = 5'd0; wbus.wr_data = "#";
        cyc();
        wbus.load = 1'b0; wbus.wr_en = 1'b0;
        chk_pulse("t4_load", 5'd0, 1'b0, 1'b0);
        cyc();
        chk("t4_out", out, "XYZXYZXYZXYZXYZX");
        chk("t4_off", 128'(offset), 128'(5'd0));

        // Load colliding with a due step, msg_len 0 clamps to 32
        en = 1'b1; step_div = 24'd2;
        cyc(); chk_pulse("t5_e1", 5'd0, 1'b0, 1'b0);
        cyc(); chk_pulse("t5_e2", 5'd0, 1'b0, 1'b0);
        cyc(); chk_pulse("t5_e3", 5'd1, 1'b1, 1'b0);
        cyc(); cyc();
        wbus.load = 1'b1; wbus.msg_len = 6'd0;
        cyc();
        wbus.load = 1'b0;
        chk_pulse("t5_coll", 5'd0, 1'b0, 1'b0);
        cyc();
        chk("t5_out", out, "#YZDEFGHIJKLMNOP");
        chk_pulse("t5_e7", 5'd0, 1'b0, 1'b0);
        cyc(); chk_pulse("t5_e8", 5'd0, 1'b0, 1'b0);
        cyc(); chk_pulse("t5_e9", 5'd1, 1'b1, 1'b0);

        // Short message scrolling right, table driven
        en = 1'b0;
        write_str("HI  ", 4);
        for (int r = 0; r < 14; r++) begin
            wbus.load = vt[r].load; wbus.msg_len = vt[r].len;
            en = vt[r].en; dir = vt[r].dir; step_div = vt[r].div;
            cyc();
            if (vt[r].chk_out) chk($sformatf("t3_out_r%0d", r), out, vt[r].e_out);
            chk_pulse($sformatf("t3_r%0d", r), vt[r].e_off, vt[r].e_step, vt[r].e_wrap);
        end
        wbus.load = 1'b0;

        // Enable freeze at cnt = 3, then step_div lowered below cnt
        en = 1'b0; dir = 1'b0; step_div = 24'd5;
        wbus.load = 1'b1; wbus.msg_len = 6'd4;
        cyc();
        wbus.load = 1'b0;
        en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc(); chk_pulse($sformatf("t6_run%0d", c), 5'd0, 1'b0, 1'b0);
        end
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc(); chk_pulse($sformatf("t6_frz%0d", c), 5'd0, 1'b0, 1'b0);
        end
        en = 1'b1;
        cyc(); chk_pulse("t6_a", 5'd0, 1'b0, 1'b0);
        cyc(); chk_pulse("t6_b", 5'd0, 1'b0, 1'b0);
        cyc(); chk_pulse("t6_c", 5'd1, 1'b1, 1'b0);
        cyc(); cyc(); cyc();
        chk_pulse("t6_f", 5'd1, 1'b0, 1'b0);
        step_div = 24'd1;
        cyc(); chk_pulse("t6_g", 5'd2, 1'b1, 1'b0);

        // Async reset mid-scroll and mid-write discards everything
        step_div = '0;
        cyc(); cyc();
        wbus.wr_en = 1'b1; wbus.wr_addr = 5'd0; wbus.wr_data = "Q";
        #3 rst = 1'b1;
        #1;
        chk("t7_out", out, SPACES);
        chk_pulse("t7_rst", 5'd0, 1'b0, 1'b0);
        cyc();
        rst = 1'b0; wbus.wr_en = 1'b0; en = 1'b0;
        wbus.load = 1'b1; wbus.msg_len = 6'd4;
        cyc();
        wbus.load = 1'b0;
        cyc();
        chk("t7_shadow_gone", out, SPACES);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/text_scroller.md
Name: text_scroller

Overview:
- Parametrised marquee engine for character displays: holds a message of up to MSG_CHARS ASCII bytes and presents a WIN_CHARS-wide window that scrolls left or right.
- Scroll rate is set by a programmable prescaler; direction and enable are runtime controls.
- Message is written byte-wise into a shadow buffer and committed atomically; the display never shows a half-written message.
- Sits between the text/control source and the display driver that consumes the window bus.

Parameters:
- MSG_CHARS, 32, message buffer capacity in characters (>= 2)
- WIN_CHARS, 16, visible window width in characters (1..MSG_CHARS)
- DIV_WIDTH, 24, width of the prescaler divide value
- Derived (localparams): AW = $clog2(MSG_CHARS); LW = $clog2(MSG_CHARS+1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  scroll enable; low freezes prescaler and offset
- dir  in  1  0 = scroll left (offset increments), 1 = scroll right (offset decrements)
- step_div  in  DIV_WIDTH  step every step_div+1 enabled cycles
- wr_en  in  1  write wr_data to shadow[wr_addr]
- wr_addr  in  AW  shadow byte address; addresses >= MSG_CHARS ignored
- wr_data  in  8  ASCII byte
- load  in  1  commit shadow -> active, latch msg_len, restart scroll
- msg_len  in  LW  message length used at load
- out  out  WIN_CHARS*8  window; char 0 in out[WIN_CHARS*8-1 -: 8] (leftmost = MSB byte)
- offset  out  AW  current index of buffer char shown in window position 0
- step  out  1  one-cycle pulse when offset advanced this cycle
- wrap  out  1  one-cycle pulse when a step makes offset return to 0

Behaviour:
- Reset (async): shadow and active filled with 0x20; len_r = MSG_CHARS; offset = 0; prescaler = 0; step = wrap = 0; out = all 0x20.
- Window: out char i = active[(offset + i) mod len_r], i = 0..WIN_CHARS-1. out is registered and reflects offset/active/len_r one cycle after they change. If len_r < WIN_CHARS, the message repeats across the window.
- Prescaler: counts only when en = 1.
  - When en = 1 and cnt >= step_div, a step occurs and cnt clears to 0; otherwise cnt increments.
  - step_div = 0 steps every enabled cycle.
  - If step_div is lowered below cnt, a step occurs on the next enabled cycle.
- Step, dir = 0: offset = (offset == len_r-1) ? 0 : offset+1.
- Step, dir = 1: offset = (offset == 0) ? len_r-1 : offset-1.
- step output: registered, high in the cycle after a step; wrap is high in the same cycle when the new offset is 0 (either direction). dir changes take effect at the next step.
- Writes: wr_en updates shadow only. Active is unaffected until load.
- Load: active <= shadow (value before any same-cycle write); len_r <= msg_len clamped (0 or > MSG_CHARS -> MSG_CHARS); offset <= 0; cnt <= 0; no step/wrap pulse.
  - Load wins over a coincident step.
  - Load is honoured regardless of en.
- len_r = 1: offset stays 0; every step still pulses step and wrap.
- Reset mid-scroll or mid-write: all state returns to reset values immediately; shadow contents are discarded.

Decomposition:
- Shared package text_pkg: CHAR_SPACE = 8'h20, char typedef logic [7:0], the dir encoding constants (DIR_LEFT = 0, DIR_RIGHT = 1).
- One natural sub-module: scroll_prescaler (en, step_div, clear -> tick). Buffers, offset arithmetic and the window mux stay in text_scroller.

Test Plan:
1. Reset defaults: assert rst mid-cycle -> out = 16 x 0x20, offset = 0, step = wrap = 0 immediately, without a clock edge.
2. Left scroll, base case: write "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345", load with msg_len = 32, step_div = 0, en = 1.
   - Response: out = "ABCDEFGHIJKLMNOP" one cycle after load, then "BCDEFGHIJKLMNOPQ", and so on.
   - After 32 steps, offset = 0 and wrap pulses once.
3. Short message, right scroll: load "HI  " with msg_len = 4, dir = 1, step_div = 2.
   - Response: out = "HI  HI  HI  HI  ".
   - Step pulses every 3 cycles; offset sequence 0 -> 3 -> 2 -> 1 -> 0; wrap on the 4th step.
4. Atomic commit: while scrolling "ABC...", write "XYZ" to shadow[0..2] without load -> out is unchanged. Then load with msg_len = 3 -> out = "XYZXYZXYZXYZXYZX", offset = 0.
5. Load/step collision and clamping: load on a cycle where a step is due with msg_len = 0 -> len_r = 32, offset = 0, no step pulse; the next step occurs after step_div+1 enabled cycles.
6. Enable freeze: with step_div = 5, drop en at cnt = 3 for 10 cycles, then raise it -> no steps while en = 0; the first step comes 3 enabled cycles after en rises.
